// File: rtl/seq_det_param.sv
// Parametrised serial sequence detector: masked pattern compare over a shifting
// history, selectable overlap mode, one-cycle match pulse and saturating match count.
module seq_det_param #(
    parameter int              PAT_W    = 5,
    parameter int              CNT_W    = 8,
    parameter logic [PAT_W-1:0] PAT_RST  = 5'b10110,
    parameter logic [PAT_W-1:0] MASK_RST = '1,
    parameter logic            OVL_RST  = 1'b1,
    localparam int             FILL_W   = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_vld,
    input  logic              seq_bit,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [PAT_W-1:0]  cfg_mask,
    input  logic              cfg_ovl,
    input  logic              clr_cnt,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic              ovl_q, ovl_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    assign hist_shift = {hist_q[PAT_W-2:0], seq_bit};
    assign fill_inc   = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    // Qualified by bit_vld and not cfg_we: a config write discards the bit.
    assign hit        = bit_vld && !cfg_we && (fill_inc == FILL_MAX)
                        && (((hist_shift ^ pat_q) & mask_q) == '0);

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;

        if (cfg_we) begin
            pat_d  = cfg_pat;
            mask_d = cfg_mask;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (bit_vld) begin
            match_d = hit;
            if (hit && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                fill_d = fill_inc;
            end
        end

        if (clr_cnt) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_RST;
            mask_q  <= MASK_RST;
            ovl_q   <= OVL_RST;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign fill      = fill_q;

endmodule
